// File: rtl/tlc_pkg.sv
// Shared types and helpers for the demand-actuated junction controller:
// state encoding, lamp codes, lamp decode and phase-timer width.
package tlc_pkg;

    // State encodings are fixed; state_o exposes them directly.
    typedef enum logic [3:0] {
        ST_MAIN  = 4'd0,
        ST_M2Y   = 4'd1,
        ST_TURN  = 4'd2,
        ST_TURNY = 4'd3,
        ST_AR1   = 4'd4,
        ST_SIDE  = 4'd5,
        ST_SIDEY = 4'd6,
        ST_AR2   = 4'd7,
        ST_FLASH = 4'd8
    } state_t;

    // Lamp codes, {R,Y,G}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    // All lamp drivers plus the pedestrian walk lamp.
    typedef struct packed {
        logic [2:0] m1;
        logic [2:0] m2;
        logic [2:0] mt;
        logic [2:0] s;
        logic       walk;
    } lamps_t;

    // Width needed to hold the largest (duration - 1) of all phases.
    function automatic int tlc_tw(input int a, input int b, input int c,
                                  input int d, input int e, input int f);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        if (f > m) m = f;
        return $clog2(m + 1);
    endfunction

    // Lamp pattern for a given state; flash_on selects the lit half of
    // night flashing, ped_serve enables the walk lamp during SIDE.
    function automatic lamps_t tlc_decode(input state_t st, input logic flash_on,
                                          input logic ped_serve);
        lamps_t l;
        l = '{m1: RED, m2: RED, mt: RED, s: RED, walk: 1'b0};
        case (st)
            ST_MAIN:  begin l.m1 = GRN; l.m2 = GRN; end
            ST_M2Y:   begin l.m1 = GRN; l.m2 = YEL; end
            ST_TURN:  begin l.m1 = GRN; l.mt = GRN; end
            ST_TURNY: begin l.m1 = YEL; l.mt = YEL; end
            ST_SIDE:  begin l.s = GRN; l.walk = ped_serve; end
            ST_SIDEY: l.s = YEL;
            ST_FLASH: begin
                if (flash_on) begin
                    l.m1 = YEL; l.m2 = YEL; l.mt = YEL; l.s = RED;
                end else begin
                    l.m1 = OFF; l.m2 = OFF; l.mt = OFF; l.s = OFF;
                end
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_junction_param_timer.sv
// Loadable down-counter with a zero flag; used for the phase timer and
// for the night-flash half-period counter.
module tlc_phase_timer #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement; the count holds at zero once reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tlc_junction_param.sv
// Demand-actuated four-approach junction controller with pedestrian walk
// and night flashing. Moore FSM on the 1 Hz junction tick; lamp outputs
// are registered so they change on the same edge as the state.
// sensor_s, ped_req and night_mode are level inputs sampled every tick;
// there is no handshake, a request is simply remembered until served.
module tlc_junction_param
    import tlc_pkg::*;
#(
    parameter int T_MAIN   = 7,
    parameter int T_TURN   = 5,
    parameter int T_SIDE   = 3,
    parameter int T_YEL    = 2,
    parameter int T_ALLRED = 1,
    parameter int T_FLASH  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_s,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic       ped_walk,
    output logic [3:0] state_o
);

    localparam int TW = tlc_tw(T_MAIN, T_TURN, T_SIDE, T_YEL, T_ALLRED, T_FLASH);

    localparam logic [TW-1:0] L_MAIN   = TW'(T_MAIN - 1);
    localparam logic [TW-1:0] L_TURN   = TW'(T_TURN - 1);
    localparam logic [TW-1:0] L_SIDE   = TW'(T_SIDE - 1);
    localparam logic [TW-1:0] L_YEL    = TW'(T_YEL - 1);
    localparam logic [TW-1:0] L_ALLRED = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] L_FLASH  = TW'(T_FLASH - 1);

    state_t  state, state_nx;
    logic    flash, flash_nx;
    logic    dem_side, dem_ped, ped_serve;
    logic    dem_side_nx, dem_ped_nx, ped_serve_nx;
    lamps_t  lamps_q;

    logic    tmr_zero, tmr_load;
    logic    fl_zero, fl_load;
    logic [TW-1:0] tmr_val;
    logic    demand, enter_side;

    // Timer reload value for the state being entered.
    function automatic logic [TW-1:0] load_for(input state_t s);
        case (s)
            ST_MAIN:                    return L_MAIN;
            ST_TURN:                    return L_TURN;
            ST_SIDE:                    return L_SIDE;
            ST_M2Y, ST_TURNY, ST_SIDEY: return L_YEL;
            ST_AR1, ST_AR2:             return L_ALLRED;
            default:                    return '0;
        endcase
    endfunction

    assign demand     = dem_side | dem_ped | sensor_s | ped_req;
    assign enter_side = (state == ST_AR1) && tmr_zero && demand;

    // Next-state and flash-phase selection.
    always_comb begin
        state_nx = state;
        flash_nx = flash;
        case (state)
            ST_MAIN:  if (tmr_zero) state_nx = ST_M2Y;
            ST_M2Y:   if (tmr_zero) state_nx = ST_TURN;
            ST_TURN:  if (tmr_zero) state_nx = ST_TURNY;
            ST_TURNY: if (tmr_zero) state_nx = ST_AR1;
            ST_AR1: begin
                if (tmr_zero) begin
                    if (demand) begin
                        state_nx = ST_SIDE;
                    end else if (night_mode) begin
                        state_nx = ST_FLASH;
                        flash_nx = 1'b1;
                    end else begin
                        state_nx = ST_MAIN;
                    end
                end
            end
            ST_SIDE:  if (tmr_zero) state_nx = ST_SIDEY;
            ST_SIDEY: if (tmr_zero) state_nx = ST_AR2;
            ST_AR2: begin
                if (tmr_zero) begin
                    if (night_mode) begin
                        state_nx = ST_FLASH;
                        flash_nx = 1'b1;
                    end else begin
                        state_nx = ST_MAIN;
                    end
                end
            end
            ST_FLASH: begin
                if (fl_zero) begin
                    if (night_mode) begin
                        flash_nx = ~flash;
                    end else begin
                        state_nx = ST_AR2;
                        flash_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = ST_MAIN;
                flash_nx = 1'b0;
            end
        endcase
    end

    // Demand latches: set in any state, cleared on the SIDE-entry edge
    // (clear beats a simultaneous set); ped_serve captured on that edge.
    always_comb begin
        dem_side_nx  = enter_side ? 1'b0 : (dem_side | sensor_s);
        dem_ped_nx   = enter_side ? 1'b0 : (dem_ped | ped_req);
        ped_serve_nx = enter_side ? (dem_ped | ped_req) : ped_serve;
    end

    // Timer strobes: reload on every state change, otherwise count down.
    always_comb begin
        tmr_load = (state_nx != state);
        tmr_val  = load_for(state_nx);
        fl_load  = (state_nx == ST_FLASH) && ((state != ST_FLASH) || fl_zero);
    end

    tlc_phase_timer #(.W(TW), .RST_VAL(L_MAIN)) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (~tmr_load),
        .zero     (tmr_zero)
    );

    tlc_phase_timer #(.W(TW), .RST_VAL('0)) u_flash_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (fl_load),
        .load_val (L_FLASH),
        .dec      (~fl_load),
        .zero     (fl_zero)
    );

    // FSM state, flags and registered lamp outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_MAIN;
            flash     <= 1'b0;
            dem_side  <= 1'b0;
            dem_ped   <= 1'b0;
            ped_serve <= 1'b0;
            lamps_q   <= tlc_decode(ST_MAIN, 1'b0, 1'b0);
        end else begin
            state     <= state_nx;
            flash     <= flash_nx;
            dem_side  <= dem_side_nx;
            dem_ped   <= dem_ped_nx;
            ped_serve <= ped_serve_nx;
            lamps_q   <= tlc_decode(state_nx, flash_nx, ped_serve_nx);
        end
    end

    assign light_M1 = lamps_q.m1;
    assign light_M2 = lamps_q.m2;
    assign light_MT = lamps_q.mt;
    assign light_S  = lamps_q.s;
    assign ped_walk = lamps_q.walk;
    assign state_o  = state;

endmodule

// File: doc/tlc_junction_param.md
Name: tlc_junction_param

Overview:
- Parametrised, demand-actuated successor to the fixed-time four-approach junction controller.
- Approaches: main road M1, opposite main M2, main right-turn MT, side road S.
- Phase durations are parameters. The side phase runs only on vehicle or pedestrian demand. Adds a pedestrian walk signal and a night flashing mode.
- Moore FSM clocked at the 1 Hz junction tick; it sits directly behind the lamp drivers.

Parameters:
- T_MAIN, 7, cycles M1+M2 green (legal range 1..255, same for all durations)
- T_TURN, 5, cycles M1+MT green
- T_SIDE, 3, cycles S green / pedestrian walk
- T_YEL, 2, cycles of every yellow interval
- T_ALLRED, 1, cycles all-red clearance
- T_FLASH, 1, half-period of night flashing, in cycles
- TW, derived localparam: $clog2(max duration + 1), phase timer width

Ports:
- clk  in  1  junction tick clock
- rst  in  1  asynchronous, active-low reset
- sensor_s  in  1  side-road vehicle detector, level, sampled every cycle
- ped_req  in  1  pedestrian push-button, sampled every cycle
- night_mode  in  1  request for the flashing mode
- light_M1  out  3  {R,Y,G}, one-hot or 000
- light_M2  out  3  {R,Y,G}
- light_MT  out  3  {R,Y,G}
- light_S  out  3  {R,Y,G}
- ped_walk  out  1  pedestrian walk lamp
- state_o  out  4  current state encoding, for debug

Behaviour:
- Encodings: RED=100, YEL=010, GRN=001, OFF=000.
- Outputs decode from the state register and the flash/ped_serve flags only, so they change on the same edge as the state.
- Timer: on entry to a state, load (duration−1). Decrement each cycle. The state exits on the edge where timer==0, so each state lasts exactly its duration.
- States, each listed as M1/M2/MT/S, then the next state:
  - MAIN (0): G/G/R/R, T_MAIN -> M2Y
  - M2Y (1): G/Y/R/R, T_YEL -> TURN
  - TURN (2): G/R/G/R, T_TURN -> TURNY
  - TURNY (3): Y/R/Y/R, T_YEL -> AR1
  - AR1 (4): R/R/R/R, T_ALLRED -> SIDE if demand, else MAIN; FLASH instead if night_mode=1 and there is no demand
  - SIDE (5): R/R/R/G, T_SIDE -> SIDEY
  - SIDEY (6): R/R/R/Y, T_YEL -> AR2
  - AR2 (7): R/R/R/R, T_ALLRED -> FLASH if night_mode=1, else MAIN
  - FLASH (8): flash phase on: M1/M2/MT=Y, S=R; flash phase off: all OFF. Toggles every T_FLASH cycles and starts in the on phase. night_mode=0 sampled at a half-period end -> AR2, then MAIN.
- Demand: dem_side sets on sensor_s=1 and dem_ped sets on ped_req=1, in any cycle and any state. The demand term used at AR1 is dem_side|dem_ped|sensor_s|ped_req.
- On the edge entering SIDE:
  - ped_serve <= dem_ped|ped_req.
  - Both latches clear; the clear wins over a set on that edge.
  - Requests during SIDE or SIDEY re-set the latches for the next cycle.
- ped_walk = (state==SIDE) & ped_serve. It is 0 in every other state.
- night_mode is ignored except at the AR1, AR2 and FLASH decision points listed above.
- Reset (rst=0), asynchronous and immediate:
  - state=MAIN, timer=T_MAIN−1, latches, ped_serve and flash flag = 0.
  - Outputs: M1=001, M2=001, MT=100, S=100, ped_walk=0, state_o=0.
  - The same applies when rst asserts mid-phase or mid-FLASH. After release the cycle restarts with a full MAIN phase.
- Safety invariants:
  - S is never GRN/YEL while any main lamp is GRN/YEL.
  - M2 and MT are never both non-red.
  - Every green-to-red transition passes through YEL.
- state_o encodings above are fixed.

Decomposition:
- Package tlc_pkg holds:
  - state enum (4-bit, values above)
  - lamp constants RED/YEL/GRN/OFF
  - a function computing TW.
- Sub-module tlc_phase_timer (load value, load strobe, decrement, zero flag, width TW) is instantiated once for the phase timer. The flash half-period counter reuses the same module.

Test Plan:
- Reset, then release with no demand -> MAIN 7, M2Y 2, TURN 5, TURNY 2, AR1 1 cycles, then MAIN again; period is 17 cycles; S stays RED and ped_walk stays 0 throughout.
- sensor_s pulsed for 1 cycle during TURN -> after AR1: SIDE 3, SIDEY 2, AR2 1; period is 23 cycles; ped_walk=0.
- ped_req pulsed during MAIN -> SIDE is entered with ped_walk=1 for exactly 3 cycles; latches read 0 on the cycle after entry.
- ped_req pulsed on the SIDE-entry edge -> ped_walk=1 that phase and the latch stays clear. ped_req pulsed during SIDEY -> SIDE is served again on the next cycle.
- night_mode=1 from cycle 0 with no demand -> FLASH after AR1; main lamps alternate 010/000 each cycle and S alternates 100/000. night_mode=0 -> AR2 for 1 cycle, then MAIN.
- rst asserted mid-TURN (cycle 10) and mid-FLASH -> outputs reach reset values with no clock edge; restart timing matches the first scenario. Safety invariants are checked by assertions on every cycle.
